// File: rtl/xadc_scan_sequencer_pkg.sv
// Shared definitions for the XADC scan sequencer: FSM encodings, sample
// width, default DRP status addresses and the per-channel result record.
package xadc_scan_sequencer_pkg;

    localparam int SAMPLE_W = 12;

    // FSM encodings
    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_WAIT_FRAME = 3'd1;
    localparam logic [2:0] S_ISSUE      = 3'd2;
    localparam logic [2:0] S_WAIT_RDY   = 3'd3;
    localparam logic [2:0] S_ACCUM      = 3'd4;
    localparam logic [2:0] S_STORE      = 3'd5;
    localparam logic [2:0] S_COMMIT     = 3'd6;

    // XADC DRP status register addresses
    localparam logic [6:0] ADDR_TEMP    = 7'h00;
    localparam logic [6:0] ADDR_VCCINT  = 7'h01;
    localparam logic [6:0] ADDR_VCCAUX  = 7'h02;
    localparam logic [6:0] ADDR_VBRAM   = 7'h06;
    localparam logic [6:0] ADDR_VCCPINT = 7'h0D;
    localparam logic [6:0] ADDR_VCCPAUX = 7'h0E;
    localparam logic [6:0] ADDR_VCCODDR = 7'h0F;
    localparam logic [6:0] ADDR_VAUX0   = 7'h10;
    localparam logic [6:0] ADDR_VAUX1   = 7'h11;
    localparam logic [6:0] ADDR_VAUX6   = 7'h16;
    localparam logic [6:0] ADDR_VAUX7   = 7'h17;
    localparam logic [6:0] ADDR_VAUX14  = 7'h1E;
    localparam logic [6:0] ADDR_VAUX15  = 7'h1F;

    // 13-channel default scan list, channel 0 in the LSBs
    localparam logic [13*7-1:0] DEFAULT_CH_ADDRS = {
        ADDR_VAUX1,  ADDR_VAUX0,   ADDR_VCCODDR, ADDR_VCCPAUX, ADDR_VCCPINT,
        ADDR_VBRAM,  ADDR_VCCAUX,  ADDR_TEMP,    ADDR_VAUX15,  ADDR_VAUX14,
        ADDR_VAUX7,  ADDR_VAUX6,   ADDR_VCCINT
    };

    typedef struct packed {
        logic [SAMPLE_W-1:0] code;
        logic                ovr;
    } chan_res_t;

endpackage

// File: rtl/xadc_avg_accum.sv
// Sample accumulator: sums 2^AVG_LOG2 samples, tracks over-range, and
// presents the truncated mean (or full scale when over-range was seen).
module xadc_avg_accum
    import xadc_scan_sequencer_pkg::*;
#(
    parameter int AVG_LOG2 = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clear_i,
    input  logic                add_i,
    input  logic [SAMPLE_W-1:0] sample_i,
    input  logic                ovr_i,
    output logic                done_o,
    output logic [SAMPLE_W-1:0] result_o,
    output logic                ovr_o
);

    localparam int ACC_W = SAMPLE_W + AVG_LOG2;
    localparam int CNT_W = AVG_LOG2 + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);

    logic [ACC_W-1:0] acc_q;
    logic [CNT_W-1:0] cnt_q;
    logic             ovr_q;

    // Accumulate on add, wipe on clear (clear wins)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            cnt_q <= '0;
            ovr_q <= 1'b0;
        end else if (clear_i) begin
            acc_q <= '0;
            cnt_q <= '0;
            ovr_q <= 1'b0;
        end else if (add_i) begin
            acc_q <= acc_q + ACC_W'(sample_i);
            cnt_q <= cnt_q + CNT_W'(1);
            ovr_q <= ovr_q | ovr_i;
        end
    end

    // The add that fills the set is the one flagged done
    assign done_o   = add_i && (cnt_q == CNT_LAST);
    assign ovr_o    = ovr_q;
    assign result_o = ovr_q ? {SAMPLE_W{1'b1}} : acc_q[ACC_W-1:AVG_LOG2];

endmodule

// File: rtl/xadc_scan_sequencer.sv
// Multi-channel XADC scanner: walks the DRP address list once per frame,
// averages each channel and double-buffers results for the display side.
module xadc_scan_sequencer
    import xadc_scan_sequencer_pkg::*;
#(
    parameter int              N_CH         = 13,
    parameter logic [N_CH*7-1:0] CH_ADDRS   = DEFAULT_CH_ADDRS,
    parameter int              AVG_LOG2     = 2,
    parameter int              FRAME_CYCLES = 10000000,
    parameter int              DRP_TIMEOUT  = 64,
    parameter logic [15:0]     OVR_THRESH   = 16'hFFD0
) (
    input  logic        clk,
    input  logic        rst,
    output logic [6:0]  drp_daddr,
    output logic        drp_den,
    input  logic [15:0] drp_do,
    input  logic        drp_drdy,
    input  logic [3:0]  rd_ch,
    output logic [11:0] rd_data,
    output logic        rd_ovr,
    output logic        scan_done,
    output logic        busy,
    output logic        timeout_err
);

    localparam int FW = $clog2(FRAME_CYCLES + 1);
    localparam int TW = $clog2(DRP_TIMEOUT + 1);
    localparam logic [FW-1:0] FRAME_LAST = FW'(FRAME_CYCLES - 1);
    localparam logic [TW-1:0] TMO_LAST   = TW'(DRP_TIMEOUT - 1);
    localparam logic [3:0]    CH_LAST    = 4'(N_CH - 1);

    logic [2:0]          state_q, state_d;
    logic [3:0]          ch_q, ch_d;
    logic [FW-1:0]       frame_q;
    logic [TW-1:0]       tmo_q;
    logic [SAMPLE_W-1:0] sample_q;
    logic                smp_ovr_q;
    logic [6:0]          daddr_q, next_addr;
    logic                den_q, timeout_q, scan_done_q;
    logic [11:0]         rd_data_q;
    logic                rd_ovr_q;
    chan_res_t           shadow_q [N_CH];
    chan_res_t           vis_q    [N_CH];
    chan_res_t           rd_sel;
    logic                scan_start;
    logic                acc_done, acc_ovr;
    logic [SAMPLE_W-1:0] acc_result;

    xadc_avg_accum #(.AVG_LOG2(AVG_LOG2)) u_accum (
        .clk      (clk),
        .rst_n    (rst),
        .clear_i  (state_q == S_STORE),
        .add_i    (state_q == S_ACCUM),
        .sample_i (sample_q),
        .ovr_i    (smp_ovr_q),
        .done_o   (acc_done),
        .result_o (acc_result),
        .ovr_o    (acc_ovr)
    );

    // Next-state, next-channel and DRP address selection
    always_comb begin
        state_d   = state_q;
        ch_d      = ch_q;
        next_addr = '0;
        case (state_q)
            S_IDLE: begin
                state_d = S_ISSUE;
                ch_d    = '0;
            end
            S_WAIT_FRAME: if (frame_q >= FRAME_LAST) begin
                state_d = S_ISSUE;
                ch_d    = '0;
            end
            S_ISSUE:    state_d = S_WAIT_RDY;
            S_WAIT_RDY: if (drp_drdy || tmo_q == TMO_LAST) state_d = S_ACCUM;
            S_ACCUM:    state_d = acc_done ? S_STORE : S_ISSUE;
            S_STORE: begin
                if (ch_q == CH_LAST) begin
                    state_d = S_COMMIT;
                end else begin
                    state_d = S_ISSUE;
                    ch_d    = ch_q + 4'd1;
                end
            end
            S_COMMIT:   state_d = S_WAIT_FRAME;
            default:    state_d = S_IDLE;
        endcase
        for (int i = 0; i < N_CH; i++)
            if (ch_d == 4'(i)) next_addr = CH_ADDRS[i*7 +: 7];
    end

    assign scan_start = (state_d == S_ISSUE) &&
                        (state_q == S_IDLE || state_q == S_WAIT_FRAME);

    // FSM state and channel pointer
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            ch_q    <= '0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
        end
    end

    // DRP strobe/address, per-read timeout and sample capture
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            den_q     <= 1'b0;
            daddr_q   <= '0;
            tmo_q     <= '0;
            sample_q  <= '0;
            smp_ovr_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            den_q <= (state_d == S_ISSUE);
            if (state_d == S_ISSUE) daddr_q <= next_addr;
            if (state_q == S_ISSUE)
                tmo_q <= '0;
            else if (state_q == S_WAIT_RDY)
                tmo_q <= tmo_q + TW'(1);
            if (state_q == S_WAIT_RDY) begin
                if (drp_drdy) begin
                    sample_q  <= drp_do[15:4];
                    smp_ovr_q <= (drp_do > OVR_THRESH);
                end else if (tmo_q == TMO_LAST) begin
                    // abandoned read contributes zero to the average
                    sample_q  <= '0;
                    smp_ovr_q <= 1'b0;
                    timeout_q <= 1'b1;
                end
            end
        end
    end

    // Frame counter: zeroed at scan start, saturates at the frame length
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            frame_q <= '0;
        else if (scan_start)
            frame_q <= '0;
        else if (frame_q < FRAME_LAST)
            frame_q <= frame_q + FW'(1);
    end

    // Shadow bank fills per channel; visible bank swaps in whole on commit
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N_CH; i++) begin
                shadow_q[i] <= '0;
                vis_q[i]    <= '0;
            end
            scan_done_q <= 1'b0;
        end else begin
            if (state_q == S_STORE)
                for (int i = 0; i < N_CH; i++)
                    if (ch_q == 4'(i)) shadow_q[i] <= '{code: acc_result, ovr: acc_ovr};
            if (state_q == S_COMMIT)
                for (int i = 0; i < N_CH; i++) vis_q[i] <= shadow_q[i];
            scan_done_q <= (state_q == S_COMMIT);
        end
    end

    // Readback mux; out-of-range channels read as zero
    always_comb begin
        rd_sel = '0;
        for (int i = 0; i < N_CH; i++)
            if (rd_ch == 4'(i)) rd_sel = vis_q[i];
    end

    // Registered readback, one cycle behind rd_ch
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_data_q <= '0;
            rd_ovr_q  <= 1'b0;
        end else begin
            rd_data_q <= rd_sel.code;
            rd_ovr_q  <= rd_sel.ovr;
        end
    end

    assign drp_den     = den_q;
    assign drp_daddr   = daddr_q;
    assign rd_data     = rd_data_q;
    assign rd_ovr      = rd_ovr_q;
    assign scan_done   = scan_done_q;
    assign timeout_err = timeout_q;
    assign busy        = (state_q != S_IDLE) && (state_q != S_WAIT_FRAME);

endmodule

// File: tb/tb_xadc_scan_sequencer.sv
// Directed bench for xadc_scan_sequencer: 3 channels, 4-sample averaging,
// 200-cycle frame, DRP responder answering 4 cycles after each strobe.
module tb_xadc_scan_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [6:0]  drp_daddr;
    logic        drp_den;
    logic [15:0] drp_do;
    logic        drp_drdy;
    logic [3:0]  rd_ch = 4'd0;
    logic [11:0] rd_data;
    logic        rd_ovr, scan_done, busy, timeout_err;

    logic        rsp_drdy = 1'b0, spur_drdy = 1'b0;
    logic [15:0] rsp_do = 16'h0, spur_do = 16'h0;
    assign drp_drdy = rsp_drdy | spur_drdy;
    assign drp_do   = spur_drdy ? spur_do : rsp_do;

    logic [15:0] tbl  [12];
    bit          drop [12];
    logic [6:0]  addr_log [12];
    int          start_cyc [8];
    int          checks = 0, failures = 0;
    int          cyc = 0, den_total = 0, done_cyc = 0;

    xadc_scan_sequencer #(
        .N_CH(3), .CH_ADDRS({7'h1F, 7'h16, 7'h01}), .AVG_LOG2(2),
        .FRAME_CYCLES(200), .DRP_TIMEOUT(64), .OVR_THRESH(16'hFFD0)
    ) dut (
        .clk(clk), .rst(rst), .drp_daddr(drp_daddr), .drp_den(drp_den),
        .drp_do(drp_do), .drp_drdy(drp_drdy), .rd_ch(rd_ch), .rd_data(rd_data),
        .rd_ovr(rd_ovr), .scan_done(scan_done), .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // strobe/commit logger
    always @(negedge clk) begin
        if (!rst) den_total = 0;
        else begin
            if (drp_den) begin
                if (den_total < 12) addr_log[den_total] = drp_daddr;
                if (den_total % 12 == 0 && den_total / 12 < 8) start_cyc[den_total/12] = cyc;
                den_total++;
            end
            if (scan_done) done_cyc = cyc;
        end
    end

    // DRP responder: drdy sampled on the 4th edge after the strobe
    initial begin
        int idx, k;
        idx = 0;
        forever begin
            @(negedge clk);
            if (!rst) idx = 0;
            else if (drp_den === 1'b1) begin
                k = idx % 12;
                idx++;
                if (!drop[k]) begin
                    repeat (4) @(posedge clk);
                    #1 rsp_do = tbl[k]; rsp_drdy = 1'b1;
                    @(posedge clk);
                    #1 rsp_drdy = 1'b0;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic fill(input logic [15:0] v0, input logic [15:0] v1, input logic [15:0] v2,
                        input bit d2);
        for (int s = 0; s < 4; s++) begin
            tbl[s] = v0; tbl[4+s] = v1; tbl[8+s] = v2;
            drop[s] = 1'b0; drop[4+s] = 1'b0; drop[8+s] = d2;
        end
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (scan_done !== 1'b1 && n < 2000);
        chk(tag, {31'd0, scan_done}, 32'd1);
    endtask

    task automatic rd(input logic [3:0] ch, input logic [11:0] exp_d, input logic exp_o,
                      input string tag);
        @(negedge clk);
        rd_ch = ch;
        @(negedge clk);
        chk({tag, "_data"}, {20'd0, rd_data}, {20'd0, exp_d});
        chk({tag, "_ovr"},  {31'd0, rd_ovr},  {31'd0, exp_o});
    endtask

    initial begin
        int n;
        fill(16'h8000, 16'h8000, 16'h8000, 1'b0);
        repeat (3) @(negedge clk);
        chk("rst_den",  {31'd0, drp_den}, 0);
        chk("rst_addr", {25'd0, drp_daddr}, 0);
        chk("rst_data", {20'd0, rd_data}, 0);
        chk("rst_ovr",  {31'd0, rd_ovr}, 0);
        chk("rst_done", {31'd0, scan_done}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_tmo",  {31'd0, timeout_err}, 0);
        rst = 1'b1;

        // scan 1: every read returns 16'h8000
        wait_done("scan1_done");
        fill(16'h1000, 16'h4000, 16'h8000, 1'b0);
        tbl[1] = 16'h1010; tbl[2] = 16'h1020; tbl[3] = 16'h1030; tbl[5] = 16'hFFE0;
        chk("scan1_dens", den_total, 12);
        chk("scan1_busy", {31'd0, busy}, 0);
        chk("addr_ch0", {25'd0, addr_log[0]}, 32'h01);
        chk("addr_ch0s3", {25'd0, addr_log[3]}, 32'h01);
        chk("addr_ch1", {25'd0, addr_log[4]}, 32'h16);
        chk("addr_ch2", {25'd0, addr_log[8]}, 32'h1F);
        chk("scan1_tmo", {31'd0, timeout_err}, 0);
        @(negedge clk);
        chk("done_pulse", {31'd0, scan_done}, 0);
        rd(4'd0, 12'h800, 1'b0, "s1_ch0");
        rd(4'd1, 12'h800, 1'b0, "s1_ch1");
        rd(4'd2, 12'h800, 1'b0, "s1_ch2");
        rd(4'd15, 12'h000, 1'b0, "s1_ch15");

        // spurious drdy while waiting for the frame
        @(negedge clk);
        spur_do = 16'hFFFF; spur_drdy = 1'b1;
        @(negedge clk);
        spur_drdy = 1'b0;
        chk("spur_busy", {31'd0, busy}, 0);
        chk("spur_dens", den_total, 12);
        chk("spur_tmo", {31'd0, timeout_err}, 0);
        rd(4'd0, 12'h800, 1'b0, "spur_ch0");

        // scan 2: truncated mean on ch0, over-range on ch1
        wait_done("scan2_done");
        fill(16'h2000, 16'h3000, 16'h8000, 1'b1);
        chk("frame_1_2", start_cyc[1] - start_cyc[0], 200);
        rd(4'd0, 12'h101, 1'b0, "s2_ch0");
        rd(4'd1, 12'hFFF, 1'b1, "s2_ch1");
        rd(4'd2, 12'h800, 1'b0, "s2_ch2");
        chk("scan2_tmo", {31'd0, timeout_err}, 0);

        // scan 3: ch2 never answers, scan overruns the frame
        wait_done("scan3_done");
        fill(16'h5550, 16'h6660, 16'h7770, 1'b0);
        chk("frame_2_3", start_cyc[2] - start_cyc[1], 200);
        chk("scan3_tmo", {31'd0, timeout_err}, 1);
        chk("scan3_busy", {31'd0, busy}, 0);
        rd(4'd0, 12'h200, 1'b0, "s3_ch0");
        rd(4'd1, 12'h300, 1'b0, "s3_ch1");
        rd(4'd2, 12'h000, 1'b0, "s3_ch2");
        chk("overrun_start", start_cyc[3] - done_cyc, 1);
        rd(4'd0, 12'h200, 1'b0, "s3_ch0b");

        // scan 4: reset while waiting on the first read of ch1
        n = 0;
        while (den_total < 41 && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("reach_ch1", den_total, 41);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("mrst_den",  {31'd0, drp_den}, 0);
        chk("mrst_addr", {25'd0, drp_daddr}, 0);
        chk("mrst_data", {20'd0, rd_data}, 0);
        chk("mrst_ovr",  {31'd0, rd_ovr}, 0);
        chk("mrst_done", {31'd0, scan_done}, 0);
        chk("mrst_busy", {31'd0, busy}, 0);
        chk("mrst_tmo",  {31'd0, timeout_err}, 0);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        rd(4'd0, 12'h000, 1'b0, "post_ch0");
        rd(4'd1, 12'h000, 1'b0, "post_ch1");
        chk("post_busy", {31'd0, busy}, 1);
        wait_done("scan5_done");
        rd(4'd0, 12'h555, 1'b0, "s5_ch0");
        rd(4'd1, 12'h666, 1'b0, "s5_ch1");
        rd(4'd2, 12'h777, 1'b0, "s5_ch2");
        chk("s5_tmo", {31'd0, timeout_err}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
